// File: rtl/seg7_byte_display.sv
// Output-port stage: latches the byte written to OUT_ADDR and shows it on one 7-segment digit
// as high nibble / low nibble / blank, dp = halt. Define SEG7_HALT_BLINK_EN to blink dp on halt.
module seg7_byte_display #(
    parameter logic [4:0]  OUT_ADDR     = 5'h1F,
    parameter int unsigned DWELL_CYCLES = 5_000_000,
    parameter int unsigned GAP_CYCLES   = 1_000_000,
    parameter int unsigned BLINK_CYCLES = 2_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [4:0] addr,
    input  logic [7:0] wdata,
    input  logic       halt,
    output logic [7:0] seg_out
);

    localparam int unsigned MAX_CYCLES = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES);

    if (DWELL_CYCLES < 2 || GAP_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_bad_params
        $error("seg7_byte_display: invalid cycle parameters");
    end

    typedef enum logic [1:0] {StIdle, StShowHi, StShowLo, StGap} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    data_q, data_d;
    logic [6:0]    seg_d;
    logic          dp_d;
    logic          capture;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign capture = we && (addr == OUT_ADDR);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        if (capture) begin
            // A capture overrides any phase end on the same edge.
            state_d = StShowHi;
            cnt_d   = '0;
            data_d  = wdata;
        end else begin
            case (state_q)
                StShowHi: begin
                    if (cnt_q == CW'(DWELL_CYCLES - 1)) begin
                        state_d = StShowLo;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StShowLo: begin
                    if (cnt_q == CW'(DWELL_CYCLES - 1)) begin
                        state_d = StGap;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StGap: begin
                    if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                        state_d = StShowHi;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Segments are registered from next-state values so a capture is visible one edge later.
    always_comb begin
        seg_d = 7'h00;
        case (state_d)
            StShowHi: seg_d = hex_to_seg(data_d[7:4]);
            StShowLo: seg_d = hex_to_seg(data_d[3:0]);
            default:  seg_d = 7'h00;
        endcase
    end

`ifdef SEG7_HALT_BLINK_EN
    localparam int unsigned BW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;

    logic          halt_q;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;

    always_comb begin
        dp_d        = seg_out[7];
        blink_cnt_d = blink_cnt_q;
        if (!halt) begin
            dp_d        = 1'b0;
            blink_cnt_d = '0;
        end else if (!halt_q) begin
            dp_d        = 1'b1;
            blink_cnt_d = '0;
        end else if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
            dp_d        = ~seg_out[7];
            blink_cnt_d = '0;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_q      <= 1'b0;
            blink_cnt_q <= '0;
        end else begin
            halt_q      <= halt;
            blink_cnt_q <= blink_cnt_d;
        end
    end
`else
    assign dp_d = halt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            data_q  <= 8'h00;
            seg_out <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            seg_out <= {dp_d, seg_d};
        end
    end

endmodule

// File: tb/tb_seg7_byte_display.sv
// Scoreboard bench for seg7_byte_display: stimulus queues the expected seg_out per edge,
// a monitor pops and compares one entry after every rising edge.
module tb_seg7_byte_display;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       we = 1'b0;
    logic [4:0] addr = 5'h00;
    logic [7:0] wdata = 8'h00;
    logic       halt = 1'b0;
    logic [7:0] seg_out;

    int checks = 0;
    int errors = 0;
    int step_no = 0;
    logic [7:0] exp_q[$];

    seg7_byte_display #(
        .OUT_ADDR    (5'h1F),
        .DWELL_CYCLES(4),
        .GAP_CYCLES  (2),
        .BLINK_CYCLES(3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .halt   (halt),
        .seg_out(seg_out)
    );

    always #5 clk = ~clk;

    // Expected digit for 8'h3A at position p within a 10-cycle display period.
    function automatic logic [7:0] base_3a(input int p);
        if ((p % 10) < 4) return 8'h4F;
        else if ((p % 10) < 8) return 8'h77;
        else return 8'h00;
    endfunction

    function automatic logic blink_dp(input int k);
`ifdef SEG7_HALT_BLINK_EN
        return ((k / 3) % 2) == 0;
`else
        return (k >= 0);
`endif
    endfunction

    task automatic step(input logic w, input logic [4:0] a, input logic [7:0] d, input logic h,
                        input logic [7:0] e);
        @(negedge clk);
        we    = w;
        addr  = a;
        wdata = d;
        halt  = h;
        exp_q.push_back(e);
    endtask

    task automatic idle_step(input logic [7:0] e);
        step(1'b0, 5'h00, 8'h00, 1'b0, e);
    endtask

    task automatic check_now(input string name, input logic [7:0] got, input logic [7:0] e);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: seg_out=%h expected %h", name, got, e);
        end
    endtask

    // Monitor: one output per edge, compared against the oldest expectation.
    always @(posedge clk) begin
        logic [7:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            step_no++;
            checks++;
            if (seg_out !== e) begin
                errors++;
                $display("FAIL scoreboard step %0d: seg_out=%h expected %h", step_no, seg_out, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n;
        #1 rst = 1'b1;
        #2 check_now("reset_async", seg_out, 8'h00);
        repeat (2) @(negedge clk);
        check_now("reset_held", seg_out, 8'h00);
        rst = 1'b0;

        // Idle: no writes, digit stays blank.
        repeat (20) idle_step(8'h00);

        // Basic display over three periods; a write to 5'h1E lands mid-sequence.
        step(1'b1, 5'h1F, 8'h3A, 1'b0, 8'h4F);
        for (int p = 1; p < 30; p++) begin
            if (p == 15) step(1'b1, 5'h1E, 8'hFF, 1'b0, base_3a(p));
            else idle_step(base_3a(p));
        end

        // Overwrite on the 2nd cycle of SHOW_LO.
        for (int p = 30; p < 36; p++) idle_step(base_3a(p));
        step(1'b1, 5'h1F, 8'hF0, 1'b0, 8'h71);
        repeat (3) idle_step(8'h71);
        repeat (4) idle_step(8'h3F);
        repeat (2) idle_step(8'h00);
        // Overwrite on the final GAP edge.
        step(1'b1, 5'h1F, 8'hF0, 1'b0, 8'h71);
        repeat (3) idle_step(8'h71);
        repeat (4) idle_step(8'h3F);
        repeat (2) idle_step(8'h00);

        // Halt indicator raised during SHOW_HI of 8'h3A.
        step(1'b1, 5'h1F, 8'h3A, 1'b0, 8'h4F);
        for (int k = 0; k < 12; k++)
            step(1'b0, 5'h00, 8'h00, 1'b1, {blink_dp(k), base_3a(k + 1)[6:0]});
        for (int p = 13; p < 16; p++) idle_step(base_3a(p));

        // Asynchronous reset between edges during SHOW_LO.
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_now("reset_mid_lo", seg_out, 8'h00);
        @(posedge clk);
        #2 check_now("reset_held_edge", seg_out, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) idle_step(8'h00);
        step(1'b1, 5'h1F, 8'h3A, 1'b0, 8'h4F);
        repeat (3) idle_step(8'h4F);
        idle_step(8'h77);

        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_byte_display.md
# seg7_byte_display

Output-port stage that sits directly downstream of the byte computer core. It snoops the core's write bus and latches the byte written to the output address. It shows that byte on a single 7-segment digit as a repeating high-nibble / low-nibble / blank sequence, with the decimal point reporting `halt`. It replaces the direct `odata` to `uo_out` connection in the top-level wrapper.

## Interface
Parameters:
- `OUT_ADDR`, default 5'h1F: bus address that this port decodes.
- `DWELL_CYCLES`, default 5_000_000: clock cycles each nibble is shown. Must be ≥ 2.
- `GAP_CYCLES`, default 1_000_000: clock cycles of blank digit after the low nibble. Must be ≥ 1.
- `BLINK_CYCLES`, default 2_500_000: half-period of the halt blink. Used only with `SEG7_HALT_BLINK_EN`.

Ports:
- `clk` in 1: system clock. All state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `we` in 1: core write strobe.
- `addr` in 5: core bus address.
- `wdata` in 8: core write data (the core's `odata`).
- `halt` in 1: core halted flag.
- `seg_out` out 8: {dp, g, f, e, d, c, b, a}. Active-high, registered.

## Operation
- **Capture:**
  - When `we` = 1 and `addr` == `OUT_ADDR` at a rising edge, `data_q <= wdata`, FSM goes to SHOW_HI, and the phase counter clears to 0.
  - Any other `addr` is ignored.
- **FSM states:** IDLE, SHOW_HI, SHOW_LO, GAP.
  - IDLE: reset state, held until the first capture. Segments a–g are blank.
  - SHOW_HI: segments show `data_q[7:4]` for DWELL_CYCLES cycles, then go to SHOW_LO.
  - SHOW_LO: segments show `data_q[3:0]` for DWELL_CYCLES cycles, then go to GAP.
  - GAP: segments a–g are blank for GAP_CYCLES cycles, then go to SHOW_HI.
- **Phase counter:**
  - Width is `$clog2` of max(DWELL_CYCLES, GAP_CYCLES).
  - Counts 0..N-1. The transition happens on the edge where count == N-1, and the count returns to 0.
- **Simultaneous events:** a capture on the same edge as a phase end takes priority. The result is SHOW_HI with count 0, using the new data.
- **Hex decode, a–g, values 0..F:** 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- **Decimal point:**
  - `seg_out[7]` = registered `halt`.
  - It is independent of the FSM state, so it is also driven in IDLE and GAP.
- **Reset:**
  - `seg_out` = 8'h00, state IDLE, `data_q` = 8'h00, counters 0.
  - Reset takes effect immediately, including mid-phase.

## Timing
- `seg_out` is a register computed from the next-state value of state, `data_q` and `halt`.
  - A capture at edge N makes the high-nibble pattern visible right after edge N.
  - The pattern is held for exactly DWELL_CYCLES edges.
- A change on `halt` sampled at edge N shows on `seg_out[7]` after edge N.
- One full display cycle is 2·DWELL_CYCLES + GAP_CYCLES clocks.
- There is no backpressure: every qualifying write is accepted. Back-to-back writes each restart the sequence, and the last one wins.

## Configuration
- `SEG7_HALT_BLINK_EN` defined:
  - While `halt` = 1, dp toggles every BLINK_CYCLES cycles.
  - dp goes to 1 on the edge that samples the `halt` rising edge, and the blink counter clears to 0 on that same edge.
  - dp = 0 whenever `halt` = 0.
- Macro not defined: dp simply follows `halt`, and no blink counter is built.

## Test plan
All tests use `OUT_ADDR` = 5'h1F, DWELL_CYCLES = 4, GAP_CYCLES = 2, BLINK_CYCLES = 3.
- **Reset and idle:** assert `rst`, release, run 20 cycles with no writes.
  - `seg_out` = 8'h00 throughout.
- **Basic display:** write 8'h3A to addr 5'h1F.
  - `seg_out` = 4F for 4 cycles, then 77 for 4, then 00 for 2.
  - The sequence repeats, checked for 3 periods.
- **Address filter:** write 8'hFF to addr 5'h1E while showing 8'h3A.
  - The sequence is undisturbed.
- **Mid-phase overwrite:** write 8'hF0 on the 2nd cycle of SHOW_LO; separately, write on the exact final GAP edge.
  - Both cases: next `seg_out` = 71 for a full 4 cycles, then 3F.
- **Halt indicator:**
  - Without the macro, raising `halt` during SHOW_HI of 8'h3A gives `seg_out` = CF one edge later.
  - With `SEG7_HALT_BLINK_EN`, dp alternates 1,1,1,0,0,0 while `halt` is held.
- **Asynchronous reset mid-operation:** pulse `rst` between clock edges during SHOW_LO.
  - `seg_out` = 00 immediately.
  - The FSM stays in IDLE until the next qualifying write.
